hamming74_serializer: RTL

HAMMING74_SERIALIZER -- requirements
Module: hamming74_serializer

---
 rtl/hamming_pkg.sv | 25 ++
 rtl/hamming74_enc.sv | 14 +
 rtl/hamming74_serializer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) constants, FSM state type and the codeword encode function.
package hamming_pkg;

  localparam int CW_LEN   = 7;
  localparam int DATA_LEN = 4;
  localparam int GAP_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Codeword bit i carries transmit position i+1: p0,p1,d0,p2,d1,d2,d3.
  function automatic logic [CW_LEN-1:0] hamming74_encode(input logic [DATA_LEN-1:0] d);
    logic p0;
    logic p1;
    logic p2;
    p0 = d[0] ^ d[1] ^ d[3];
    p1 = d[0] ^ d[2] ^ d[3];
    p2 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p2, d[0], p1, p0};
  endfunction

endpackage

// File: rtl/hamming74_enc.sv
// Combinational Hamming(7,4) encoder feeding the holding register and the bypass path.
module hamming74_enc
  import hamming_pkg::*;
(
  input  logic [DATA_LEN-1:0] i_data,
  output logic [CW_LEN-1:0]   o_cw
);

  // Pure function of the nibble; codeword bit 0 is transmitted first.
  always_comb begin
    o_cw = hamming74_encode(i_data);
  end

endmodule

// File: rtl/hamming74_serializer.sv
// Hamming(7,4) serializer: one-entry holding register plus a 7-bit shift register,
// emitting one codeword bit per clock with sof/eof framing and optional idle gaps.
module hamming74_serializer
  import hamming_pkg::*;
#(
  parameter int GAP_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_LEN-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                ser_out,
  output logic                ser_valid,
  output logic                sof,
  output logic                eof
);

  localparam logic [2:0]       LAST_BIT = 3'(CW_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  // Registered state
  state_t              r_state;
  logic [2:0]          r_bit_cnt;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic [CW_LEN-1:0]   r_shift;
  logic [CW_LEN-1:0]   r_hold_cw;
  logic                r_hold_full;
  logic                r_ser_out;
  logic                r_ser_valid;
  logic                r_sof;
  logic                r_eof;
  logic                r_in_ready;

  // Next-state and combinational helpers
  state_t              w_state_next;
  logic [2:0]          w_bit_cnt_next;
  logic [2:0]          w_bit_inc;
  logic [GAP_W-1:0]    w_gap_cnt_next;
  logic [CW_LEN-1:0]   w_shift_next;
  logic [CW_LEN-1:0]   w_hold_cw_next;
  logic                w_hold_full_next;
  logic                w_ser_out_next;
  logic                w_ser_valid_next;
  logic                w_sof_next;
  logic                w_eof_next;
  logic                w_in_ready_next;
  logic [CW_LEN-1:0]   w_enc_cw;
  logic [CW_LEN-1:0]   w_src_cw;
  logic                w_accept;
  logic                w_avail;
  logic                w_load;
  logic                w_take_hold;
  logic                w_bypass;
  logic                w_store;

  hamming74_enc u_enc (
    .i_data (in_data),
    .o_cw   (w_enc_cw)
  );

  // Handshake and next-codeword source: the holding register always has priority,
  // otherwise a nibble accepted this cycle goes straight to the shift register.
  always_comb begin
    w_accept = in_valid & r_in_ready;
    w_avail  = r_hold_full | w_accept;
    w_src_cw = r_hold_full ? r_hold_cw : w_enc_cw;
  end

  // FSM next-state, shift register and registered-output next values.
  always_comb begin
    w_state_next     = r_state;
    w_bit_cnt_next   = r_bit_cnt;
    w_gap_cnt_next   = r_gap_cnt;
    w_shift_next     = r_shift;
    w_ser_out_next   = 1'b0;
    w_ser_valid_next = 1'b0;
    w_sof_next       = 1'b0;
    w_eof_next       = 1'b0;
    w_load           = 1'b0;
    w_bit_inc        = r_bit_cnt + 3'd1;

    case (r_state)
      IDLE: begin
        w_bit_cnt_next = 3'd0;
        if (w_avail) begin
          w_load = 1'b1;
        end
      end

      SHIFT: begin
        if (r_bit_cnt != LAST_BIT) begin
          w_bit_cnt_next   = w_bit_inc;
          w_shift_next     = {1'b0, r_shift[CW_LEN-1:1]};
          w_ser_out_next   = r_shift[1];
          w_ser_valid_next = 1'b1;
          w_eof_next       = (w_bit_inc == LAST_BIT);
        end else if (GAP_CYCLES == 0) begin
          // Last bit leaves now: chain the next codeword without a bubble.
          w_bit_cnt_next = 3'd0;
          w_shift_next   = '0;
          if (w_avail) begin
            w_load = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end else begin
          w_bit_cnt_next = 3'd0;
          w_gap_cnt_next = '0;
          w_shift_next   = '0;
          w_state_next   = GAP;
        end
      end

      GAP: begin
        w_bit_cnt_next = 3'd0;
        if (r_gap_cnt == GAP_LAST) begin
          w_gap_cnt_next = '0;
          if (w_avail) begin
            w_load = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end else begin
          w_gap_cnt_next = r_gap_cnt + 4'd1;
        end
      end

      default: begin
        w_state_next   = IDLE;
        w_bit_cnt_next = 3'd0;
        w_gap_cnt_next = '0;
        w_shift_next   = '0;
      end
    endcase

    // A new codeword starts: present its first bit right away with sof.
    if (w_load) begin
      w_state_next     = SHIFT;
      w_bit_cnt_next   = 3'd0;
      w_shift_next     = w_src_cw;
      w_ser_out_next   = w_src_cw[0];
      w_ser_valid_next = 1'b1;
      w_sof_next       = 1'b1;
    end
  end

  // Holding register: emptied when it feeds the shift register, filled by an
  // accepted nibble that did not bypass. Ready is derived from the next fill state,
  // so acceptance never depends combinationally on in_valid.
  always_comb begin
    w_take_hold      = w_load & r_hold_full;
    w_bypass         = w_load & ~r_hold_full;
    w_store          = w_accept & ~w_bypass;
    w_hold_full_next = (r_hold_full & ~w_take_hold) | w_store;
    w_hold_cw_next   = w_store ? w_enc_cw : r_hold_cw;
    w_in_ready_next  = ~w_hold_full_next;
  end

  // State and output registers with synchronous reset that aborts any codeword.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_bit_cnt   <= 3'd0;
      r_gap_cnt   <= '0;
      r_shift     <= '0;
      r_hold_cw   <= '0;
      r_hold_full <= 1'b0;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_gap_cnt   <= w_gap_cnt_next;
      r_shift     <= w_shift_next;
      r_hold_cw   <= w_hold_cw_next;
      r_hold_full <= w_hold_full_next;
      r_ser_out   <= w_ser_out_next;
      r_ser_valid <= w_ser_valid_next;
      r_sof       <= w_sof_next;
      r_eof       <= w_eof_next;
      r_in_ready  <= w_in_ready_next;
    end
  end

  // Outputs come straight from flops.
  always_comb begin
    in_ready  = r_in_ready;
    ser_out   = r_ser_out;
    ser_valid = r_ser_valid;
    sof       = r_sof;
    eof       = r_eof;
  end

endmodule
